// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg: state encoding and sizing shared by the instruction loader
package imem_loader_pkg;
    localparam int ADDR_W_DEF = 10;

    typedef enum logic [2:0] {IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR} state_t;

    function automatic int max_words(input int aw);
        return 1 << aw;
    endfunction

    localparam int MAX_WORDS = max_words(ADDR_W_DEF);
endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if: byte stream in, instruction-memory write port out
interface imem_loader_if #(parameter int ADDR_W = 10, parameter int WORD_W = 16);
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [WORD_W-1:0] imem_wdata;
    modport master (output rx_data, rx_valid, input rx_ready, imem_we, imem_addr, imem_wdata);
    modport slave  (input rx_data, rx_valid, output rx_ready, imem_we, imem_addr, imem_wdata);
endinterface

// File: rtl/imem_loader_xor_accum.sv
// xor_accum: 8-bit running XOR with synchronous clear and enable
module xor_accum (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       clr,
    input  logic       en,
    input  logic [7:0] din,
    output logic [7:0] acc
);
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) acc <= '0;
        else if (clr) acc <= '0;
        else if (en)  acc <= acc ^ din;
endmodule

// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that frames a byte stream into instruction-memory writes
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int WORD_W = 16
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    imem_loader_if.slave bus,
    output logic         cpu_hold,
    output logic         done,
    output logic         error
);
    localparam logic [16:0] max_n = 17'(max_words(ADDR_W));

    state_t            state, nxt;
    logic              hs, clr, we;
    logic [7:0]        acc, hi, len_hi;
    logic [15:0]       n, left;
    logic [ADDR_W-1:0] idx, addr;
    logic [WORD_W-1:0] wdata;

    assign hs  = bus.rx_valid && bus.rx_ready;
    assign n   = {len_hi, bus.rx_data};
    assign clr = nxt == LEN_HI && state != LEN_HI;

    xor_accum u_xor (
        .clock  (clock),
        .reset_n(reset_n),
        .clr    (clr),
        .en     (hs && state != CHECK),
        .din    (bus.rx_data),
        .acc    (acc)
    );

    always_comb begin
        nxt = state;
        case (state)
            IDLE, DONE, ERR: nxt = start ? LEN_HI : state;
            LEN_HI:          nxt = hs ? LEN_LO : state;
            LEN_LO:          nxt = !hs ? state : {1'b0, n} > max_n ? ERR : n == 16'd0 ? CHECK : DATA_HI;
            DATA_HI:         nxt = hs ? DATA_LO : state;
            DATA_LO:         nxt = !hs ? state : left == 16'd1 ? CHECK : DATA_HI;
            CHECK:           nxt = !hs ? state : bus.rx_data == acc ? DONE : ERR;
            default:         nxt = IDLE;
        endcase
    end

    // the write is registered, so an async reset also cancels a pending word
    always_ff @(posedge clock or negedge reset_n)
        if (!reset_n) begin
            state  <= IDLE;
            len_hi <= '0;
            hi     <= '0;
            left   <= '0;
            idx    <= '0;
            we     <= 1'b0;
            addr   <= '0;
            wdata  <= '0;
        end else begin
            state <= nxt;
            we    <= hs && state == DATA_LO;
            if (clr) idx <= '0;
            if (hs && state == LEN_HI) len_hi <= bus.rx_data;
            if (hs && state == LEN_LO) left <= n;
            if (hs && state == DATA_HI) hi <= bus.rx_data;
            if (hs && state == DATA_LO) begin
                addr  <= idx;
                wdata <= WORD_W'({hi, bus.rx_data});
                idx   <= idx + ADDR_W'(1);
                left  <= left - 16'd1;
            end
        end

    assign bus.rx_ready   = state inside {LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK};
    assign bus.imem_we    = we;
    assign bus.imem_addr  = addr;
    assign bus.imem_wdata = wdata;
    assign cpu_hold       = state != DONE;
    assign done           = state == DONE;
    assign error          = state == ERR;
endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: random frames against a frame-level model of the loader
module tb_imem_loader;
    import imem_loader_pkg::*;

    logic clock = 0, reset_n = 0, start = 0;
    logic cpu_hold, done, error;
    int n_cmp = 0, n_bad = 0, cyc = 0;
    logic [25:0] wq[$];

    imem_loader_if #(.ADDR_W(10), .WORD_W(16)) bus ();

    imem_loader dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .bus     (bus),
        .cpu_hold(cpu_hold),
        .done    (done),
        .error   (error)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(negedge clock) if (bus.imem_we) wq.push_back({bus.imem_addr, bus.imem_wdata});

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] xor_of(input logic [15:0] len, input logic [15:0] w[$]);
        logic [7:0] x = len[15:8] ^ len[7:0];
        foreach (w[i]) x ^= w[i][15:8] ^ w[i][7:0];
        return x;
    endfunction

    task automatic send_byte(input logic [7:0] b, input int gap);
        int t = 0;
        while ($urandom_range(99) < gap) begin
            bus.rx_valid = 0;
            bus.rx_data  = 8'($urandom);
            @(negedge clock);
        end
        bus.rx_data  = b;
        bus.rx_valid = 1;
        while (!bus.rx_ready && t < 100) begin
            @(negedge clock);
            t++;
        end
        if (!bus.rx_ready) check("ready_timeout", bus.rx_ready, 1);
        @(negedge clock);
        bus.rx_valid = 0;
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_rx_ready"}, bus.rx_ready, 0);
        check({tag, "_we"}, bus.imem_we, 0);
        check({tag, "_addr"}, bus.imem_addr, 0);
        check({tag, "_wdata"}, bus.imem_wdata, 0);
        check({tag, "_hold"}, cpu_hold, 1);
        check({tag, "_done"}, done, 0);
        check({tag, "_error"}, error, 0);
    endtask

    task automatic run_frame(input logic [15:0] len, input logic [15:0] w[$], input logic [7:0] csum,
                             input int gap, input string tag);
        bit over = len > MAX_WORDS;
        bit ok;
        int c0, el, nexp;
        wq.delete();
        @(negedge clock);
        start = 1;
        c0 = cyc;
        @(negedge clock);
        start = 0;
        send_byte(len[15:8], gap);
        send_byte(len[7:0], gap);
        if (!over) begin
            foreach (w[i]) begin
                send_byte(w[i][15:8], gap);
                send_byte(w[i][7:0], gap);
            end
            send_byte(csum, gap);
        end
        el = cyc - c0 - 1;
        ok = !over && csum == xor_of(len, w);
        nexp = over ? 0 : int'(len);
        check({tag, "_done"}, done, ok);
        check({tag, "_error"}, error, !ok);
        check({tag, "_hold"}, cpu_hold, !ok);
        if (gap == 0 && !over) check({tag, "_cycles"}, el, 2 * int'(len) + 3);
        @(negedge clock);
        check({tag, "_rx_ready"}, bus.rx_ready, 0);
        check({tag, "_nwrites"}, wq.size(), nexp);
        for (int i = 0; i < nexp && i < wq.size(); i++)
            check({tag, "_write"}, wq[i], {10'(i % MAX_WORDS), w[i]});
    endtask

    initial begin
        logic [15:0] w[$];
        logic [15:0] len;
        logic [7:0]  cs;
        bus.rx_valid = 0;
        bus.rx_data  = 0;
        repeat (2) @(negedge clock);
        check_reset("reset");
        reset_n = 1;

        w.push_back(16'h5000);
        w.push_back(16'h5104);
        run_frame(16'd2, w, 8'h07, 0, "two_word");
        run_frame(16'd2, w, 8'h06, 0, "bad_chk");
        run_frame(16'd2, w, 8'h07, 40, "gaps");
        w.delete();
        run_frame(16'd0, w, 8'h00, 0, "n_zero");
        run_frame(16'h0401, w, 8'h00, 0, "oversize");

        wq.delete();
        @(negedge clock);
        start = 1;
        @(negedge clock);
        start = 0;
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h50, 0);
        bus.rx_data  = 8'h00;
        bus.rx_valid = 1;
        @(posedge clock);
        #1 reset_n = 0;
        bus.rx_valid = 0;
        @(negedge clock);
        check_reset("mid_reset");
        check("mid_reset_nwrites", wq.size(), 0);
        reset_n = 1;
        w.push_back(16'h5000);
        w.push_back(16'h5104);
        run_frame(16'd2, w, 8'h07, 0, "reload");

        for (int k = 0; k < 20; k++) begin
            w.delete();
            len = k == 5 ? 16'(MAX_WORDS) : k == 9 ? 16'(MAX_WORDS + 1 + $urandom_range(0, 3000)) : 16'($urandom_range(0, 6));
            if (len <= MAX_WORDS) for (int i = 0; i < int'(len); i++) w.push_back(16'($urandom));
            cs = xor_of(len, w);
            if ($urandom_range(3) == 0) cs ^= 8'($urandom_range(1, 255));
            run_frame(len, w, cs, k == 5 ? 0 : int'($urandom_range(0, 50)), "rand");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time instruction loader for the 16-bit single-cycle CPU: the write side of the instruction memory, which the CPU otherwise only reads (`IR = IMemory[PC>>2]`). It accepts a byte stream over a valid/ready handshake, assembles 16-bit instruction words high byte first and writes them to consecutive instruction-memory word addresses. It validates the stream with a length header and XOR checksum, and holds the CPU until a load completes cleanly.

## Interface
Parameters:
- `ADDR_W`, 10, instruction-memory word-address width (1024 words).
- `WORD_W`, 16, instruction width; fixed at 16, two bytes per word.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  sole clock; all state updates on posedge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  single-cycle pulse; begins a load from IDLE, DONE or ERR.
- `rx_data`  in  8  stream byte.
- `rx_valid`  in  1  `rx_data` is valid.
- `rx_ready`  out  1  loader accepts a byte this cycle; a byte transfers when `rx_valid && rx_ready`.
- `imem_we`  out  1  instruction-memory write strobe, one cycle per word.
- `imem_addr`  out  ADDR_W  word address (the CPU fetches word PC>>2).
- `imem_wdata`  out  16  instruction word.
- `cpu_hold`  out  1  CPU must not advance PC while high.
- `done`  out  1  load completed with good checksum; sticky.
- `error`  out  1  load aborted; sticky.

## Operation
- Frame: LEN_HI, LEN_LO (N, 16-bit big-endian word count), then N×(HI, LO) instruction bytes, then one CHK byte. CHK equals the XOR of every preceding frame byte, length bytes included.
- States and transitions:
  - IDLE: `start` → LEN_HI.
  - LEN_HI: byte accepted → LEN_LO.
  - LEN_LO: byte accepted → one of:
    - ERR if N > 2^ADDR_W;
    - CHECK if N = 0;
    - DATA_HI otherwise.
  - DATA_HI: byte accepted → DATA_LO.
  - DATA_LO: byte accepted → DATA_HI, or CHECK after the Nth word.
  - CHECK: byte accepted → DONE if it equals the running XOR, else ERR.
  - DONE / ERR: `start` → LEN_HI.
- `start` is ignored in every state other than IDLE, DONE and ERR.
- `rx_ready` is 1 in LEN_HI, LEN_LO, DATA_HI, DATA_LO and CHECK, and 0 elsewhere.
- A byte in LEN_LO, DATA_LO or CHECK is accepted the same cycle the loader enters that state; there are no stall cycles.
- Word write: the DATA_HI byte is latched. When the DATA_LO byte is accepted, the next cycle presents:
  - `imem_we` = 1;
  - `imem_wdata` = {hi, lo};
  - `imem_addr` = word index.
- The word index then increments. It starts at 0 for each load and wraps modulo 2^ADDR_W; wrap can only occur at N = 2^ADDR_W, after the last write.
- Checksum: the running XOR clears on entry to LEN_HI and updates on every accepted byte except CHK.
- `cpu_hold` = 1 in every state except DONE. On restart from DONE, hold reasserts the cycle after `start`.
- `done` = 1 only in DONE; `error` = 1 only in ERR.
- Words already written before an error stay in memory; `cpu_hold` stays 1.

## Timing
- Reset (async assert, sync release): state = IDLE, and outputs are:
  - `rx_ready` = 0, `imem_we` = 0, `imem_addr` = 0, `imem_wdata` = 0;
  - `cpu_hold` = 1, `done` = 0, `error` = 0;
  - XOR and counters = 0.
- Reset mid-load aborts immediately. No further writes are issued, including a write pending from the last DATA_LO byte.
- Write latency: `imem_we` is high exactly one cycle, the cycle after the DATA_LO handshake.
- Throughput: one byte per cycle maximum. A 2+2N+1 byte frame with `rx_valid` held high completes in 2N+3 cycles after LEN_HI entry.
- Gaps (`rx_valid` = 0) stall without state change. `rx_data` is sampled only on a handshake.
- `done` / `error` / `cpu_hold` change the cycle after the CHK handshake.
- `start` coincident with `rx_valid` in IDLE: the byte is not consumed that cycle.

## Structure
- Shared package `imem_loader_pkg`:
  - state enum (IDLE, LEN_HI, LEN_LO, DATA_HI, DATA_LO, CHECK, DONE, ERR);
  - `MAX_WORDS` = 2^ADDR_W.
- Sub-module `xor_accum`: 8-bit running XOR with clear and enable; it is also reusable for a later data-memory loader.
- Top holds the FSM, word counter, high-byte latch and write registers.

## Test plan
- Two-word load: bytes 00 02 50 00 51 04 XOR=07 → writes addr0=5000, addr1=5104; `done`=1; `cpu_hold`=0; `error`=0.
- Bad checksum: the same frame with CHK=06 → both writes occur, `error`=1, `cpu_hold` stays 1, `done`=0.
- N=0: bytes 00 00 00 → no `imem_we`; `done`=1 on the cycle after CHK.
- Oversize length: 04 01 (N=1025) → `error` the cycle after LEN_LO; no further `rx_ready`.
- Backpressure and gaps: random `rx_valid` gaps during the two-word load → identical writes, and `imem_we` count = 2.
- Reset mid-load: `reset_n` low after the DATA_LO handshake of word 0 → no write; outputs at reset values; a new `start` reloads from addr 0.
